// File: rtl/router_port_arbiter_if.sv
// rtl/router_port_arbiter_if.sv - two-phase handshake bundle between requesters, arbiter and shared output
interface router_port_arbiter_if #(
    parameter int n    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   in_req;
    logic [NREQ-1:0]   in_ack;
    logic [NREQ*n-1:0] in_data;
    logic              out_req;
    logic              out_ack;
    logic [n-1:0]      out_data;
    logic [NREQ-1:0]   grant;
    logic [15:0]       flit_count;

    // Arbiter side
    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, grant, flit_count
    );

    // Environment side: requesters plus output channel
    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, grant, flit_count
    );
endinterface

// File: rtl/router_port_arbiter.sv
// rtl/router_port_arbiter.sv - round-robin arbiter of NREQ two-phase flit channels onto one output channel
module router_port_arbiter #(
    parameter int n    = 32,
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    router_port_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   in_ack_q, in_ack_d;
    logic              out_req_q, out_req_d;
    logic [n-1:0]      out_data_q, out_data_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [15:0]       count_q, count_d;

    logic [NREQ-1:0]   pending;
    logic              found;
    logic [IW-1:0]     winner;
    int                idx;

    // A requester is pending while its toggle differs from our acknowledge toggle
    assign pending = bus.in_req ^ in_ack_q;

    // Round-robin pick: scan from the index after the last winner, wrapping to 0
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Next-state and output update; everything holds unless a transition fires
    always_comb begin
        state_d    = state_q;
        in_ack_d   = in_ack_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                // out_ack is not looked at here, so a stray toggle has no effect
                if (found) begin
                    out_data_d = bus.in_data[int'(winner)*n +: n];
                    out_req_d  = ~out_req_q;
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    last_d     = winner;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // grant is one-hot on the owner, so XOR toggles only its ack bit
                if (bus.out_ack == out_req_q) begin
                    in_ack_d = in_ack_q ^ grant_q;
                    grant_d  = '0;
                    count_d  = count_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset makes index 0 the first in line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ack_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            grant_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            count_q    <= count_d;
        end
    end

    assign bus.in_ack     = in_ack_q;
    assign bus.out_req    = out_req_q;
    assign bus.out_data   = out_data_q;
    assign bus.grant      = grant_q;
    assign bus.flit_count = count_q;
endmodule

// File: doc/router_port_arbiter.md
ROUTER_PORT_ARBITER -- requirements
Module: router_port_arbiter

Interface
REQ-001 Parameter n, default 32, flit width in bits (header in [n-1:n-4]: [n-1:n-2] address, [n-3:n-4] deltas).
REQ-002 Parameter NREQ, default 4, number of requesting input channels (index 0 = proc, 1..3 = port1..port3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (block held in reset while rst = 0).
REQ-005 in_req  input  NREQ  two-phase request toggle per requester, synchronous to clk.
REQ-006 in_ack  output  NREQ  two-phase acknowledge toggle per requester.
REQ-007 in_data  input  NREQ*n  flit of requester i in bits [i*n +: n], stable while request pending.
REQ-008 out_req  output  1  two-phase request toggle toward the shared output channel.
REQ-009 out_ack  input  1  two-phase acknowledge toggle from the shared output channel, synchronous to clk.
REQ-010 out_data  output  n  registered flit presented to the output channel.
REQ-011 grant  output  NREQ  one-hot owner of the output channel; all-zero when idle.
REQ-012 flit_count  output  16  number of flits fully delivered since reset.

Function
REQ-013 Requester i is pending when in_req[i] != in_ack[i]; output busy when out_req != out_ack.
REQ-014 FSM states: IDLE, SEND; reset state IDLE.
REQ-015 IDLE: if any requester pending, select winner by round-robin starting at index (last_winner+1) mod NREQ, wrapping past NREQ-1 to 0.
REQ-016 IDLE with winner w, same edge: out_data <= in_data[w], out_req toggles, grant <= one-hot(w), last_winner <= w, go SEND.
REQ-017 IDLE with no requester pending: all outputs hold, stay IDLE.
REQ-018 SEND: when out_ack == out_req, on that edge: in_ack[w] toggles, grant <= 0, flit_count increments, go IDLE.
REQ-019 SEND with out_ack != out_req: hold out_data, out_req, grant, in_ack; stay SEND.
REQ-020 Latency: out_req toggles 1 edge after a pending request is seen in IDLE; in_ack toggles 1 edge after out_ack matches; minimum 2 cycles per flit, next grant no earlier than the edge after in_ack toggle.
REQ-021 out_data changes only on the IDLE->SEND edge; never while busy.
REQ-022 A requester whose request arrives during SEND waits; it is not lost and competes at the next IDLE arbitration.
REQ-023 Simultaneous requests: exactly one winner per arbitration; with all NREQ pending continuously, service order strictly rotates, each requester served once per NREQ flits (no starvation).
REQ-024 An out_ack toggle while IDLE is ignored (no state change, no count).
REQ-025 in_ack of non-granted requesters never changes.
REQ-026 flit_count wraps from 16'hFFFF to 16'h0000.
REQ-027 Header bits of the flit pass unmodified; the block performs no routing decisions.

Reset
REQ-028 rst = 0 asynchronously forces: state IDLE, in_ack = 0, out_req = 0, out_data = 0, grant = 0, flit_count = 0, last_winner = NREQ-1 (so index 0 has first priority).
REQ-029 Reset mid-SEND abandons the flit: no in_ack toggle, count not incremented; the upstream toggle comparison restarts from all-zero.
REQ-030 After rst rises, first arbitration occurs no earlier than the first rising clk edge with rst = 1.

Verification
REQ-031 Single: in_req[1] toggles 0->1, in_data[1]=32'h2EEEEEEE, out_ack echoes 3 cycles later -> out_req=1, out_data=32'h2EEEEEEE, grant=4'b0010; in_ack[1]=1 one edge after echo, flit_count=1.
REQ-032 All four toggle same cycle with data 32'h4FFFFFFF/32'h2EEEEEEE/32'h1DDDDDDD/32'h1CCCCCCC, ack 1 cycle after each out_req -> out_data order FFFFFFF, EEEEEEE, DDDDDDD, CCCCCCC (indices 0,1,2,3), flit_count=4.
REQ-033 Back-to-back: requester 1 re-toggles immediately after each in_ack while requester 3 pending -> grants alternate 1,3,1,3; neither served twice in a row.
REQ-034 Stall: out_ack withheld 20 cycles -> out_req, out_data, grant constant, no in_ack change; then echo -> in_ack toggles next edge.
REQ-035 Reset mid-SEND: drop rst while grant=4'b0100 -> all outputs 0 immediately; after release, pending requester 0 wins first.
REQ-036 Spurious out_ack toggle in IDLE -> no output change, flit_count unchanged.
